// File: rtl/corral_match_ctrl.sv
// Match sequencer for the corral game core: resets the core, relays moves, times out idle players and tallies results.
// Optional macro CORRAL_AUTOPLAY_EN: timeout moves come from a 4-bit LFSR instead of the constant 1.
module corral_match_ctrl #(
  parameter int ROUNDS         = 5,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_MOVES      = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       btn_enter,
  input  logic [2:0] btn_move,
  input  logic       core_ready,
  input  logic       core_gameover,
  input  logic       core_lostwon,
  output logic       core_rst_n,
  output logic       core_enter,
  output logic [2:0] core_move,
  output logic [3:0] round_num,
  output logic [3:0] wins,
  output logic [3:0] losses,
  output logic [3:0] move_count,
  output logic       reject,
  output logic       match_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_CORE, S_SETTLE, S_WAIT_INPUT, S_ISSUE, S_RELEASE, S_ROUND_END, S_DONE
  } state_t;

  localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      ROUNDS_L = 4'(ROUNDS);
  localparam logic [3:0]      MAX_L    = 4'(MAX_MOVES);

  // Two-flop synchronizers plus a delayed copy for rising-edge detection.
  logic       start_meta_q, start_sync_q, start_prev_q;
  logic       enter_meta_q, enter_sync_q, enter_prev_q;
  logic [2:0] move_meta_q, move_sync_q;
  logic       start_edge, enter_edge;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      enter_meta_q <= 1'b0;
      enter_sync_q <= 1'b0;
      enter_prev_q <= 1'b0;
      move_meta_q  <= 3'd0;
      move_sync_q  <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
      start_meta_q <= start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      enter_meta_q <= btn_enter;
      enter_sync_q <= enter_meta_q;
      enter_prev_q <= enter_sync_q;
      move_meta_q  <= btn_move;
      move_sync_q  <= move_meta_q;
    end
  end

  assign start_edge = start_sync_q & ~start_prev_q;
  assign enter_edge = enter_sync_q & ~enter_prev_q;

  logic [2:0] auto_move;
`ifdef CORRAL_AUTOPLAY_EN
  logic [3:0] lfsr_q, lfsr_d;
  assign lfsr_d    = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign auto_move = 3'(lfsr_q % 4'd5) + 3'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 4'b1001;
    else          lfsr_q <= lfsr_d;
  end
`else
  assign auto_move = 3'd1;
`endif

  state_t        state_q, state_d;
  logic          rst_cnt_q, rst_cnt_d;
  logic          issue_wait_q, issue_wait_d;
  logic          result_q, result_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          core_enter_q, core_enter_d;
  logic [2:0]    core_move_q, core_move_d;
  logic [3:0]    round_num_q, round_num_d;
  logic [3:0]    wins_q, wins_d;
  logic [3:0]    losses_q, losses_d;
  logic [3:0]    move_count_q, move_count_d;
  logic          reject_q, reject_d;
  logic          match_done_q, match_done_d;
  logic          busy_q, busy_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    issue_wait_d = issue_wait_q;
    result_d     = result_q;
    tmo_d        = tmo_q;
    core_rst_n_d = core_rst_n_q;
    core_enter_d = 1'b0;
    core_move_d  = core_move_q;
    round_num_d  = round_num_q;
    wins_d       = wins_q;
    losses_d     = losses_q;
    move_count_d = move_count_q;
    reject_d     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        core_rst_n_d = 1'b1;
        if (start_edge) begin
          wins_d       = 4'd0;
          losses_d     = 4'd0;
          move_count_d = 4'd0;
          round_num_d  = 4'd1;
          rst_cnt_d    = 1'b0;
          core_rst_n_d = 1'b0;
          state_d      = S_RST_CORE;
        end
      end
      S_RST_CORE: begin
        if (rst_cnt_q) begin
          core_rst_n_d = 1'b1;
          state_d      = S_SETTLE;
        end else begin
          rst_cnt_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (core_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT_INPUT;
        end
      end
      S_WAIT_INPUT: begin
        tmo_d = (tmo_q == TMO_LAST) ? '0 : tmo_q + TW'(1);
        if (enter_edge) begin
          if (move_sync_q inside {[3'd1:3'd5]}) begin
            core_move_d  = move_sync_q;
            core_enter_d = 1'b1;
            issue_wait_d = 1'b0;
            state_d      = S_ISSUE;
          end else begin
            reject_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          core_move_d  = auto_move;
          core_enter_d = 1'b1;
          issue_wait_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // First cycle carries the strobe; the core's verdict is read on the second.
        if (!issue_wait_q) begin
          issue_wait_d = 1'b1;
        end else if (core_ready) begin
          reject_d = 1'b1;
          tmo_d    = '0;
          state_d  = S_WAIT_INPUT;
        end else begin
          move_count_d = move_count_q + 4'd1;
          state_d      = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // The core raises gameover during its own setup, so it only counts once a move landed.
        if (core_gameover && (move_count_q != 4'd0)) begin
          result_d = core_lostwon;
          state_d  = S_ROUND_END;
        end else if (core_ready) begin
          if (move_count_q == MAX_L) begin
            result_d = 1'b0;
            state_d  = S_ROUND_END;
          end else begin
            tmo_d   = '0;
            state_d = S_WAIT_INPUT;
          end
        end
      end
      S_ROUND_END: begin
        if (result_q) wins_d   = (wins_q == 4'd15)   ? wins_q   : wins_q + 4'd1;
        else          losses_d = (losses_q == 4'd15) ? losses_q : losses_q + 4'd1;
        if (round_num_q == ROUNDS_L) begin
          state_d = S_DONE;
        end else begin
          round_num_d  = round_num_q + 4'd1;
          move_count_d = 4'd0;
          rst_cnt_d    = 1'b0;
          core_rst_n_d = 1'b0;
          state_d      = S_RST_CORE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = !(state_d inside {S_IDLE, S_DONE});
    match_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= 1'b0;
      issue_wait_q <= 1'b0;
      result_q     <= 1'b0;
      tmo_q        <= '0;
      core_rst_n_q <= 1'b0;
      core_enter_q <= 1'b0;
      core_move_q  <= 3'd0;
      round_num_q  <= 4'd0;
      wins_q       <= 4'd0;
      losses_q     <= 4'd0;
      move_count_q <= 4'd0;
      reject_q     <= 1'b0;
      match_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      issue_wait_q <= issue_wait_d;
      result_q     <= result_d;
      tmo_q        <= tmo_d;
      core_rst_n_q <= core_rst_n_d;
      core_enter_q <= core_enter_d;
      core_move_q  <= core_move_d;
      round_num_q  <= round_num_d;
      wins_q       <= wins_d;
      losses_q     <= losses_d;
      move_count_q <= move_count_d;
      reject_q     <= reject_d;
      match_done_q <= match_done_d;
      busy_q       <= busy_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign core_enter = core_enter_q;
  assign core_move  = core_move_q;
  assign round_num  = round_num_q;
  assign wins       = wins_q;
  assign losses     = losses_q;
  assign move_count = move_count_q;
  assign reject     = reject_q;
  assign match_done = match_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_corral_match_ctrl.sv
// Self-checking bench for corral_match_ctrl: directed steps plus random moves against a match-level model.
module tb_corral_match_ctrl;

  localparam int ROUNDS = 2;
  localparam int TMO    = 1000;
  localparam int MAXM   = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       btn_enter = 1'b0;
  logic [2:0] btn_move = 3'd0;
  logic       core_ready = 1'b1;
  logic       core_gameover = 1'b0;
  logic       core_lostwon = 1'b0;
  logic       core_rst_n, core_enter, reject, match_done, busy;
  logic [2:0] core_move;
  logic [3:0] round_num, wins, losses, move_count;

  corral_match_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT_CYCLES(TMO), .MAX_MOVES(MAXM)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .btn_enter(btn_enter), .btn_move(btn_move),
    .core_ready(core_ready), .core_gameover(core_gameover), .core_lostwon(core_lostwon),
    .core_rst_n(core_rst_n), .core_enter(core_enter), .core_move(core_move),
    .round_num(round_num), .wins(wins), .losses(losses), .move_count(move_count),
    .reject(reject), .match_done(match_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wait_start = 0;

  // Match-level model: what the scoreboard should read after each event.
  int m_round = 0, m_w = 0, m_l = 0, m_mc = 0;
  bit m_done = 1'b0;

  task automatic tick;
    @(negedge clock);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_score(input string tag);
    chk({tag, "_round"},  32'(round_num),  32'(m_round));
    chk({tag, "_wins"},   32'(wins),       32'(m_w));
    chk({tag, "_losses"}, 32'(losses),     32'(m_l));
    chk({tag, "_moves"},  32'(move_count), 32'(m_mc));
  endtask

  // Called at the first cycle the core reset is seen low; plays the core coming out of reset.
  task automatic core_reset_seq(input bit glitch);
    int n;
    n = 1;
    core_ready = 1'b0;
    core_gameover = 1'b0;
    core_lostwon = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    tick;
    while (core_rst_n === 1'b0 && n < 6) begin
      n++;
      tick;
    end
    chk("core_rst_low_cycles", 32'(n), 32'd2);
    if (glitch) begin
      core_gameover = 1'b1;
      core_lostwon = 1'b1;
      repeat (3) tick;
      check_score("settle_gameover");
      core_gameover = 1'b0;
      core_lostwon = 1'b0;
    end
    repeat ($urandom_range(0, 2)) tick;
    @(posedge clock);
    #1 core_ready = 1'b1;
    tick;
    tick;
    wait_start = cyc;
  endtask

  task automatic start_match(input bit glitch);
    int n;
    bit seen;
    start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      tick;
      n++;
      seen = (core_rst_n === 1'b0);
    end
    chk("start_latency_ok", 32'(seen && n >= 3 && n <= 4), 32'd1);
    m_round = 1; m_w = 0; m_l = 0; m_mc = 0; m_done = 1'b0;
    check_score("start");
    chk("start_match_done", 32'(match_done), 32'd0);
    core_reset_seq(glitch);
    start = 1'b0;
  endtask

  task automatic round_end(input bit win);
    int n;
    bit seen;
    if (win) m_w = (m_w == 15) ? 15 : m_w + 1;
    else     m_l = (m_l == 15) ? 15 : m_l + 1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      tick;
      n++;
      seen = (core_rst_n === 1'b0) || (match_done === 1'b1);
    end
    chk("round_end_seen", 32'(seen), 32'd1);
    if (m_round == ROUNDS) begin
      m_done = 1'b1;
      check_score("match_end");
      chk("match_done", 32'(match_done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      core_gameover = 1'b0;
      core_ready = 1'b1;
    end else begin
      m_round++;
      m_mc = 0;
      check_score("next_round");
      chk("next_round_not_done", 32'(match_done), 32'd0);
      core_reset_seq(1'b0);
    end
  endtask

  // Called at the cycle core_enter is seen high; plays the core's reaction to the move.
  task automatic core_respond(input bit accept, input bit end_round, input bit lw);
    @(posedge clock);
    #1 core_ready = ~accept;
    tick;
    chk("enter_one_cycle", 32'(core_enter), 32'd0);
    tick;
    if (!accept) begin
      chk("core_refuse_reject", 32'(reject), 32'd1);
      chk("core_refuse_moves", 32'(move_count), 32'(m_mc));
      wait_start = cyc;
    end else begin
      m_mc++;
      chk("accept_moves", 32'(move_count), 32'(m_mc));
      chk("accept_no_reject", 32'(reject), 32'd0);
      repeat ($urandom_range(0, 2)) tick;
      @(posedge clock);
      #1;
      if (end_round) begin
        core_gameover = 1'b1;
        core_lostwon = lw;
      end else begin
        core_ready = 1'b1;
      end
      if (end_round || m_mc == MAXM) begin
        round_end(end_round ? lw : 1'b0);
      end else begin
        tick;
        tick;
        wait_start = cyc;
      end
    end
  endtask

  task automatic do_move(input logic [2:0] mv, input bit accept, input bit end_round, input bit lw);
    int n;
    bit seen;
    btn_move = mv;
    btn_enter = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      tick;
      n++;
      seen = (core_enter === 1'b1) || (reject === 1'b1);
    end
    chk("enter_latency_ok", 32'(seen && n >= 3 && n <= 4), 32'd1);
    if (mv >= 3'd1 && mv <= 3'd5) begin
      chk("issue_enter", 32'(core_enter), 32'd1);
      chk("issue_move", 32'(core_move), 32'(mv));
      chk("issue_no_reject", 32'(reject), 32'd0);
      core_respond(accept, end_round, lw);
    end else begin
      chk("bad_move_reject", 32'(reject), 32'd1);
      chk("bad_move_no_enter", 32'(core_enter), 32'd0);
      tick;
      chk("reject_one_cycle", 32'(reject), 32'd0);
      chk("bad_move_moves", 32'(move_count), 32'(m_mc));
    end
    btn_enter = 1'b0;
    repeat (3) tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit saw_low;

    // Reset values.
    repeat (3) tick;
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_core_enter", 32'(core_enter), 32'd0);
    chk("rst_core_move", 32'(core_move), 32'd0);
    check_score("rst");
    chk("rst_reject", 32'(reject), 32'd0);
    chk("rst_match_done", 32'(match_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick;
    tick;
    chk("idle_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Match 1: bad move, core-refused move, accepted move, timeout move ending the round as a win.
    start_match(1'b1);
    do_move(3'd7, 1'b1, 1'b0, 1'b0);
    do_move(3'd2, 1'b0, 1'b0, 1'b0);
    chk("two_rejects_moves", 32'(move_count), 32'd0);
    do_move(3'd3, 1'b1, 1'b0, 1'b0);
    while (core_enter !== 1'b1 && (cyc - wait_start) < TMO + 100) tick;
    chk("timeout_cycle", 32'(cyc - wait_start), 32'(TMO));
`ifdef CORRAL_AUTOPLAY_EN
    chk("timeout_move_range", 32'(core_move >= 3'd1 && core_move <= 3'd5), 32'd1);
`else
    chk("timeout_move", 32'(core_move), 32'd1);
`endif
    core_respond(1'b1, 1'b1, 1'b1);

    // Start edges mid-match are ignored.
    start = 1'b1;
    saw_low = 1'b0;
    repeat (8) begin
      tick;
      if (core_rst_n !== 1'b1) saw_low = 1'b1;
    end
    chk("start_ignored", 32'(saw_low), 32'd0);
    check_score("start_ignored");
    start = 1'b0;
    repeat (3) tick;

    // Round 2: move limit forfeits the round.
    repeat (MAXM) do_move(3'd4, 1'b1, 1'b0, 1'b0);
    chk("match1_done_flag", 32'(m_done), 32'd1);

    // Match 2 from DONE: counters clear, every round lost on the move limit.
    start_match(1'b0);
    repeat (ROUNDS * MAXM) do_move(3'd5, 1'b1, 1'b0, 1'b0);
    chk("all_losses", 32'(losses), 32'(ROUNDS));

    // Random matches.
    for (int m = 0; m < 3; m++) begin
      start_match(1'($urandom_range(0, 1)));
      k = 0;
      while (!m_done && k < 60) begin
        do_move(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        k++;
      end
      chk("random_match_finished", 32'(m_done), 32'd1);
    end

    // Reset mid-match aborts to IDLE with cleared counters.
    start_match(1'b0);
    do_move(3'd5, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    tick;
    m_round = 0; m_w = 0; m_l = 0; m_mc = 0;
    check_score("abort");
    chk("abort_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    core_ready = 1'b1;
    tick;
    tick;
    chk("abort_idle_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
